// File: rtl/fmul_pipe_if.sv
// Operand/result handshake bundle for the pipelined FP multiplier.
interface fmul_pipe_if #(
  parameter int EW = 8,
  parameter int MW = 23
);
  localparam int W = 1 + EW + MW;

  logic [W-1:0] x1;
  logic [W-1:0] x2;
  logic         rm;
  logic         valid_in;
  logic         ready_out;
  logic [W-1:0] y;
  logic         ovf;
  logic         valid_out;
  logic         ready_in;

  modport slave (
    input  x1, x2, rm, valid_in, ready_in,
    output ready_out, y, ovf, valid_out
  );

  modport master (
    output x1, x2, rm, valid_in, ready_in,
    input  ready_out, y, ovf, valid_out
  );
endinterface

// File: rtl/fmul_pipe.sv
// 3-stage stallable IEEE-754 multiplier: unpack/partial products, normalise, round/pack.
module fmul_pipe #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input logic        clk,
  input logic        rstn,
  fmul_pipe_if.slave bus
);
  localparam int W    = 1 + EW + MW;
  localparam int M    = MW + 1;
  localparam int PW   = 2 * M;
  localparam int ML   = M / 2;
  localparam int MH   = M - ML;
  localparam int XW   = EW + 2;
  localparam int LZW  = $clog2(M + 1);
  localparam int BIAS = 2 ** (EW - 1) - 1;
  localparam int EMAX = 2 ** EW - 1;
  localparam int SAT  = MW + 3;
  localparam logic [W-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  function automatic logic [LZW-1:0] lzc(input logic [M-1:0] v);
    lzc = LZW'(M);
    for (int i = 0; i < M; i++)
      if (v[i]) lzc = LZW'(M - 1 - i);
  endfunction

  logic [2:0] r_vld_pipe;
  logic       w_en;
  assign w_en          = bus.ready_in | ~r_vld_pipe[2];
  assign bus.ready_out = w_en;

  // ---------------- S1: unpack ----------------
  logic [1:0][W-1:0] w_x;
  logic [1:0]        w_s, w_zero, w_inf, w_nan;
  logic [1:0][M-1:0] w_m;
  logic signed [XW-1:0] w_e [2];
  assign w_x = {bus.x2, bus.x1};

  for (genvar k = 0; k < 2; k++) begin : g_unpack
    logic [EW-1:0]  w_ex;
    logic [MW-1:0]  w_fr;
    logic [M-1:0]   w_sig;
    logic [LZW-1:0] w_lz;
    assign w_ex     = w_x[k][W-2:MW];
    assign w_fr     = w_x[k][MW-1:0];
    assign w_sig    = {|w_ex, w_fr};
    assign w_lz     = lzc(w_sig);
    assign w_m[k]   = w_sig << w_lz;
    // subnormals get effective exponent 1-lzc once normalised
    assign w_e[k]   = (|w_ex) ? XW'(w_ex) : XW'(1) - XW'(w_lz);
    assign w_s[k]   = w_x[k][W-1];
    assign w_zero[k] = ~|w_ex & ~|w_fr;
    assign w_inf[k]  = &w_ex & ~|w_fr;
    assign w_nan[k]  = &w_ex & |w_fr;
  end

  logic            w_sgn, w_inv, w_spec;
  logic [W-1:0]    w_spec_y;
  logic [XW-1:0]   w_esum;
  logic [M+ML-1:0] w_pp_lo;
  logic [M+MH-1:0] w_pp_hi;
  assign w_sgn    = w_s[0] ^ w_s[1];
  assign w_inv    = (|w_nan) | (w_inf[0] & w_zero[1]) | (w_inf[1] & w_zero[0]);
  assign w_spec   = w_inv | (|w_inf) | (|w_zero);
  assign w_spec_y = w_inv    ? QNAN :
                    (|w_inf) ? {w_sgn, {EW{1'b1}}, {MW{1'b0}}} :
                               {w_sgn, {(W-1){1'b0}}};
  assign w_esum   = w_e[0] + w_e[1] - XW'(BIAS);
  assign w_pp_lo  = (M+ML)'(w_m[0]) * (M+ML)'(w_m[1][ML-1:0]);
  assign w_pp_hi  = (M+MH)'(w_m[0]) * (M+MH)'(w_m[1][M-1:ML]);

  logic            r1_sgn, r1_rm, r1_spec;
  logic [W-1:0]    r1_spec_y;
  logic [XW-1:0]   r1_e;
  logic [M+ML-1:0] r1_pp_lo;
  logic [M+MH-1:0] r1_pp_hi;

  // ---------------- S2: combine and normalise ----------------
  logic [PW-1:0] w_prod, w_nsig, w_shf;
  logic [XW-1:0] w_ne, w_amt, w_sh;
  logic          w_top, w_sub, w_lost;
  assign w_prod = PW'(r1_pp_lo) + (PW'(r1_pp_hi) << ML);
  assign w_top  = w_prod[PW-1];
  // keep the leading one at the top instead of shifting right, so no bit is lost
  assign w_nsig = w_top ? w_prod : (w_prod << 1);
  assign w_ne   = r1_e + XW'(w_top);
  assign w_sub  = w_ne[XW-1] | ~|w_ne;
  assign w_amt  = XW'(1) - w_ne;
  assign w_sh   = !w_sub ? '0 : (w_amt > XW'(SAT)) ? XW'(SAT) : w_amt;
  assign w_shf  = w_nsig >> w_sh;
  assign w_lost = |(w_nsig & ~({PW{1'b1}} << w_sh));

  logic          r2_sgn, r2_rm, r2_spec, r2_g, r2_r, r2_s;
  logic [W-1:0]  r2_spec_y;
  logic [XW-1:0] r2_e;
  logic [M-1:0]  r2_m;

  // ---------------- S3: round and pack ----------------
  logic          w_inc, w_of;
  logic [M:0]    w_rsum;
  logic [XW-1:0] w_fe;
  logic [W-1:0]  w_y;
  assign w_inc  = ~r2_rm & r2_g & (r2_r | r2_s | r2_m[0]);
  assign w_rsum = {1'b0, r2_m} + (M+1)'(w_inc);
  // subnormal rounding into the hidden bit promotes to exponent 1
  assign w_fe   = (r2_e == '0) ? XW'(w_rsum[M-1]) : r2_e + XW'(w_rsum[M]);
  assign w_of   = w_fe >= XW'(EMAX);
  assign w_y    = r2_spec ? r2_spec_y :
                  w_of    ? {r2_sgn, {EW{1'b1}}, {MW{1'b0}}} :
                            {r2_sgn, w_fe[EW-1:0], w_rsum[MW-1:0]};

  logic [W-1:0] r_y;
  logic         r_ovf;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_vld_pipe <= '0;
      r_y        <= '0;
      r_ovf      <= 1'b0;
    end else if (w_en) begin
      r_vld_pipe <= {r_vld_pipe[1:0], bus.valid_in};
      r1_sgn     <= w_sgn;
      r1_rm      <= bus.rm;
      r1_spec    <= w_spec;
      r1_spec_y  <= w_spec_y;
      r1_e       <= w_esum;
      r1_pp_lo   <= w_pp_lo;
      r1_pp_hi   <= w_pp_hi;
      r2_sgn     <= r1_sgn;
      r2_rm      <= r1_rm;
      r2_spec    <= r1_spec;
      r2_spec_y  <= r1_spec_y;
      r2_e       <= w_sub ? '0 : w_ne;
      r2_m       <= w_shf[PW-1:M];
      r2_g       <= w_shf[M-1];
      r2_r       <= w_shf[M-2];
      r2_s       <= (|w_shf[M-3:0]) | w_lost;
      r_y        <= w_y;
      r_ovf      <= ~r2_spec & w_of;
    end
  end

  assign bus.y         = r_y;
  assign bus.ovf       = r_ovf;
  assign bus.valid_out = r_vld_pipe[2];
endmodule

// File: tb/tb_fmul_pipe.sv
// Directed bench for fmul_pipe (binary32): latency, rounding, subnormals, specials, stall, reset.
module tb_fmul_pipe;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fmul_pipe_if #(.EW(8), .MW(23)) bus ();
  fmul_pipe #(.EW(8), .MW(23)) dut (.clk(clk), .rstn(rstn), .bus(bus.slave));

  // issue one op into an idle pipe; report result and accept-to-valid latency
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic m,
                        output logic [31:0] yo, output logic vo, output int lat);
    bus.x1 = a; bus.x2 = b; bus.rm = m; bus.valid_in = 1'b1;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    lat = 1;
    while (!bus.valid_out && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    yo = bus.y; vo = bus.ovf;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.x1 = '0; bus.x2 = '0; bus.rm = 1'b0; bus.valid_in = 1'b0; bus.ready_in = 1'b1;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.valid_out); end
    n_chk++; if (bus.y !== 32'h0) begin n_fail++; $display("FAIL reset_y got %h exp 0", bus.y); end
    n_chk++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", bus.ovf); end
    rstn = 1'b1;
    n_chk++; if (bus.ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", bus.ready_out); end
  endtask

  task automatic test_basic();
    logic [31:0] a [2] = '{32'h3FC00000, 32'hC0000000};
    logic [31:0] b [2] = '{32'h40000000, 32'h40400000};
    logic [31:0] e [2] = '{32'h40400000, 32'hC0C00000};
    logic [31:0] yo; logic vo; int lat;
    for (int i = 0; i < 2; i++) begin
      run_op(a[i], b[i], 1'b0, yo, vo, lat);
      n_chk++; if (yo !== e[i]) begin n_fail++; $display("FAIL basic_y[%0d] got %h exp %h", i, yo, e[i]); end
      n_chk++; if (vo !== 1'b0) begin n_fail++; $display("FAIL basic_ovf[%0d] got %b exp 0", i, vo); end
      n_chk++; if (lat != 3) begin n_fail++; $display("FAIL basic_latency[%0d] got %0d exp 3", i, lat); end
    end
  endtask

  task automatic test_rounding();
    int cyc;
    bus.x1 = 32'h3F800001; bus.x2 = 32'h3FC00000; bus.rm = 1'b0; bus.valid_in = 1'b1;
    @(posedge clk); #1;
    bus.rm = 1'b1;
    @(posedge clk); #1;
    bus.valid_in = 1'b0; bus.rm = 1'b0;
    cyc = 2;
    while (!bus.valid_out && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_chk++; if (cyc != 3) begin n_fail++; $display("FAIL tie_latency got %0d exp 3", cyc); end
    n_chk++; if (bus.y !== 32'h3FC00002) begin n_fail++; $display("FAIL tie_rne got %h exp 3fc00002", bus.y); end
    @(posedge clk); #1;
    n_chk++; if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL tie_second_valid got %b exp 1", bus.valid_out); end
    n_chk++; if (bus.y !== 32'h3FC00001) begin n_fail++; $display("FAIL tie_rtz got %h exp 3fc00001", bus.y); end
    @(posedge clk); #1;
  endtask

  task automatic test_subnormal_ovf();
    logic [31:0] a [3] = '{32'h00400000, 32'h00000001, 32'h7F000000};
    logic [31:0] b [3] = '{32'h40000000, 32'h3F000000, 32'h7F000000};
    logic [31:0] e [3] = '{32'h00800000, 32'h00000000, 32'h7F800000};
    logic        o [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] yo; logic vo; int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(a[i], b[i], 1'b0, yo, vo, lat);
      n_chk++; if (yo !== e[i]) begin n_fail++; $display("FAIL subovf_y[%0d] got %h exp %h", i, yo, e[i]); end
      n_chk++; if (vo !== o[i]) begin n_fail++; $display("FAIL subovf_ovf[%0d] got %b exp %b", i, vo, o[i]); end
    end
  endtask

  task automatic test_specials();
    logic [31:0] a [4] = '{32'h7F800000, 32'hFF800000, 32'h7FA00000, 32'h80000000};
    logic [31:0] b [4] = '{32'h00000000, 32'h40000000, 32'h3F800000, 32'h3F800000};
    logic [31:0] e [4] = '{32'h7FC00000, 32'hFF800000, 32'h7FC00000, 32'h80000000};
    logic [31:0] yo; logic vo; int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(a[i], b[i], 1'b0, yo, vo, lat);
      n_chk++; if (yo !== e[i]) begin n_fail++; $display("FAIL special_y[%0d] got %h exp %h", i, yo, e[i]); end
      n_chk++; if (vo !== 1'b0) begin n_fail++; $display("FAIL special_ovf[%0d] got %b exp 0", i, vo); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a [6] = '{32'h40000000, 32'h3FC00000, 32'hBF800000, 32'h40800000, 32'h41000000, 32'h3F000000};
    logic [31:0] b [6] = '{32'h40400000, 32'h3FC00000, 32'h41200000, 32'h3E800000, 32'hC0A00000, 32'h3F000000};
    logic [31:0] e [6] = '{32'h40C00000, 32'h40100000, 32'hC1200000, 32'h3F800000, 32'hC2200000, 32'h3E800000};
    int idx = 0, n_out = 0, n_stall = 0, n_extra = 0;
    logic stall_prev = 1'b0, acc;
    logic [31:0] y_prev = '0;
    for (int cyc = 0; cyc < 40 && n_out < 6; cyc++) begin
      bus.ready_in = !(cyc >= 4 && cyc <= 8);
      if (idx < 6) begin bus.x1 = a[idx]; bus.x2 = b[idx]; bus.rm = 1'b0; bus.valid_in = 1'b1; end
      else bus.valid_in = 1'b0;
      @(negedge clk);
      if (bus.valid_out && !bus.ready_in) begin
        n_stall++;
        n_chk++; if (bus.ready_out !== 1'b0) begin n_fail++; $display("FAIL bp_ready cyc %0d got %b exp 0", cyc, bus.ready_out); end
        if (stall_prev) begin
          n_chk++; if (bus.y !== y_prev) begin n_fail++; $display("FAIL bp_hold cyc %0d got %h exp %h", cyc, bus.y, y_prev); end
        end
        stall_prev = 1'b1; y_prev = bus.y;
      end else stall_prev = 1'b0;
      acc = bus.valid_in && bus.ready_out;
      if (bus.valid_out && bus.ready_in) begin
        n_chk++; if (bus.y !== e[n_out]) begin n_fail++; $display("FAIL bp_y[%0d] got %h exp %h", n_out, bus.y, e[n_out]); end
        n_out++;
      end
      @(posedge clk); #1;
      if (acc) idx++;
    end
    bus.valid_in = 1'b0; bus.ready_in = 1'b1;
    n_chk++; if (n_out != 6) begin n_fail++; $display("FAIL bp_count got %0d exp 6", n_out); end
    n_chk++; if (n_stall < 4) begin n_fail++; $display("FAIL bp_stall_cycles got %0d exp >=4", n_stall); end
    repeat (5) begin
      @(negedge clk);
      if (bus.valid_out) n_extra++;
    end
    @(posedge clk); #1;
    n_chk++; if (n_extra != 0) begin n_fail++; $display("FAIL bp_duplicate got %0d exp 0", n_extra); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] a [3] = '{32'h40000000, 32'h3FC00000, 32'hBF800000};
    logic [31:0] b [3] = '{32'h40400000, 32'h3FC00000, 32'h41200000};
    logic [31:0] yo; logic vo; int lat, n_stale = 0;
    bus.ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.x1 = a[i]; bus.x2 = b[i]; bus.rm = 1'b0; bus.valid_in = 1'b1;
      @(posedge clk); #1;
    end
    bus.valid_in = 1'b0;
    n_chk++; if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL rst_pending got %b exp 1", bus.valid_out); end
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1; bus.ready_in = 1'b1;
    n_chk++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", bus.valid_out); end
    n_chk++; if (bus.y !== 32'h0) begin n_fail++; $display("FAIL rst_y got %h exp 0", bus.y); end
    n_chk++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %b exp 0", bus.ovf); end
    n_chk++; if (bus.ready_out !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", bus.ready_out); end
    repeat (5) begin
      @(negedge clk);
      if (bus.valid_out) n_stale++;
    end
    @(posedge clk); #1;
    n_chk++; if (n_stale != 0) begin n_fail++; $display("FAIL rst_stale got %0d exp 0", n_stale); end
    run_op(32'h40800000, 32'h3E800000, 1'b0, yo, vo, lat);
    n_chk++; if (yo !== 32'h3F800000) begin n_fail++; $display("FAIL rst_next_y got %h exp 3f800000", yo); end
    n_chk++; if (lat != 3) begin n_fail++; $display("FAIL rst_next_latency got %0d exp 3", lat); end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_basic();
    test_rounding();
    test_subnormal_ovf();
    test_specials();
    test_backpressure();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
